debug_mem_reader: RTL and testbench
===================================

Name: debug_mem_reader

Overview:
- Debug-side reader for the data-memory debug port of the MEM stage.
- On a start pulse it walks every word of data memory: drives the debug address, captures the debug read data, and serialises each 32-bit word as 4 bytes to the debug UART transmitter through a start/done byte handshake.
- Sits in the debug unit, between the MEM stage debug port and the UART TX.

Parameters:
- BITS_SIZE, 32, data and address width of the memory debug port.
- SIZE_MEM_DATA, 10, number of 32-bit words to dump (word indices 0..SIZE_MEM_DATA-1).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-low reset.
- i_start  in  1  one-cycle request to begin a dump; ignored unless in IDLE.
- o_addr_mem_debug  out  BITS_SIZE  byte address to the memory debug port: word index x 4.
- i_mem_dato_debug  in  BITS_SIZE  debug read data; valid one cycle after o_addr_mem_debug changes.
- o_tx_start  out  1  one-cycle pulse; the UART latches o_tx_data.
- o_tx_data  out  8  byte to transmit.
- i_tx_done  in  1  one-cycle pulse from the UART when the byte has been sent.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when the last byte is acknowledged.

Behaviour:
- Reset (i_reset=0 at a clock edge) forces IDLE; all outputs are 0, and the word and byte counters are 0. A reset mid-dump aborts the dump with no further tx pulses.
- State IDLE: on i_start=1, go to ADDR; the word counter is already 0.
- State ADDR: o_addr_mem_debug = word_cnt*4 (registered). Next state is CAPTURE.
- State CAPTURE: latch i_mem_dato_debug into the word register. Set byte_cnt=0. Next state is SEND.
- State SEND: o_tx_start=1 for exactly this cycle. o_tx_data = word[31:24], [23:16], [15:8], [7:0] for byte_cnt 0..3 (MSB first). Next state is WAIT_TX.
- State WAIT_TX: hold o_tx_data and wait for i_tx_done. i_tx_done in any other state is ignored, including the SEND cycle itself. On i_tx_done:
  - byte_cnt<3: byte_cnt++, go to SEND.
  - byte_cnt==3 and word_cnt<SIZE_MEM_DATA-1: word_cnt++, go to ADDR.
  - byte_cnt==3 and word_cnt==SIZE_MEM_DATA-1: go to DONE.
- State DONE: o_done=1 for one cycle, clear the counters, go to IDLE.
- Latency: with i_start sampled at edge k, o_addr_mem_debug is valid after edge k+1, data is captured at edge k+2, and o_tx_start is high during the cycle after edge k+2.
- o_tx_start is never asserted twice without an intervening i_tx_done.
- The total number of o_tx_start pulses per dump is 4*SIZE_MEM_DATA.
- The word counter is sized $clog2(SIZE_MEM_DATA)+1 bits. Its zero-extension times 4 gives o_addr_mem_debug; no wrap occurs inside a dump.
- SIZE_MEM_DATA=1: after the 4th i_tx_done the block goes straight to DONE.
- i_start while busy is ignored. i_start in the same cycle as o_done is also ignored; the next accepted start is from IDLE.
- o_addr_mem_debug holds its last value in IDLE until the next dump. The memory port is read-only from this side.

Optional Feature:
- Macro: DEBUG_MEM_HEADER_EN.
- Defined: after i_start and before the first ADDR, the block sends two header bytes through the same SEND/WAIT_TX handshake:
  - 0xA5,
  - then SIZE_MEM_DATA[7:0].
  - Total pulses are 4*SIZE_MEM_DATA+2.
  - The first o_tx_start rises in the cycle after edge k+1.
- Not defined: no header; data only; timing exactly as in Behaviour.

Test Plan:
- Reset: hold i_reset=0 for 3 cycles, release -> o_busy=0, o_done=0, o_tx_start=0, o_addr_mem_debug=0.
- Single word (SIZE_MEM_DATA=1): memory word 0 = 0x12345678, pulse i_start, return i_tx_done 5 cycles after each o_tx_start -> bytes 0x12, 0x34, 0x56, 0x78 in order; o_done pulses once after the 4th i_tx_done; o_busy then drops.
- Full dump (SIZE_MEM_DATA=10): memory[i] = 0xA0000000+i -> 40 pulses; o_addr_mem_debug steps 0, 4, ..., 36; last 4 bytes are 0xA0, 0x00, 0x00, 0x09.
- Protocol robustness: send i_start mid-dump, and spurious i_tx_done in IDLE and in the SEND cycle -> no restart, no skipped or extra bytes, still 40 pulses.
- Reset mid-operation: assert i_reset=0 while in WAIT_TX of word 3 -> next cycle IDLE with outputs 0; a new i_start dumps from address 0.
- Optional feature: build with DEBUG_MEM_HEADER_EN and SIZE_MEM_DATA=10 -> first bytes 0xA5, 0x0A, then data; 42 pulses in total.

Source files
------------

// File: rtl/debug_mem_reader.sv
// rtl/debug_mem_reader.sv - walks data memory through the debug port and streams each word MSB-first to the UART TX.
// Optional DEBUG_MEM_HEADER_EN: prefixes the dump with header bytes 0xA5 and SIZE_MEM_DATA[7:0].
module debug_mem_reader #(
  parameter int BITS_SIZE     = 32,
  parameter int SIZE_MEM_DATA = 10
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  output logic [BITS_SIZE-1:0] o_addr_mem_debug,
  input  logic [BITS_SIZE-1:0] i_mem_dato_debug,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int CW = $clog2(SIZE_MEM_DATA) + 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(SIZE_MEM_DATA - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CAPTURE,
    SEND,
    WAIT_TX,
    DONE,
    HDR
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] word_cnt;
  logic [1:0]    byte_cnt;
  logic [1:0]    last_byte;
  logic [31:0]   word_reg;
  logic          hdr_phase;

  // Header phase reuses the word register and byte handshake but only emits two bytes.
  assign last_byte = hdr_phase ? 2'd1 : 2'd3;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state            <= IDLE;
      word_cnt         <= '0;
      byte_cnt         <= '0;
      word_reg         <= '0;
      hdr_phase        <= 1'b0;
      o_addr_mem_debug <= '0;
    end else begin
      state <= state_next;
      case (state)
        ADDR: o_addr_mem_debug <= BITS_SIZE'(word_cnt) << 2;
        CAPTURE: begin
          word_reg <= i_mem_dato_debug[31:0];
          byte_cnt <= '0;
        end
`ifdef DEBUG_MEM_HEADER_EN
        HDR: begin
          word_reg  <= {8'hA5, 8'(SIZE_MEM_DATA), 16'h0000};
          byte_cnt  <= '0;
          hdr_phase <= 1'b1;
        end
`endif
        WAIT_TX: begin
          if (i_tx_done) begin
            if (byte_cnt != last_byte) begin
              byte_cnt <= byte_cnt + 2'd1;
            end else if (hdr_phase) begin
              hdr_phase <= 1'b0;
            end else if (word_cnt != LAST_WORD) begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          word_cnt <= '0;
          byte_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    o_tx_start = 1'b0;
    o_done     = 1'b0;
    o_busy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (i_start) begin
`ifdef DEBUG_MEM_HEADER_EN
          state_next = HDR;
`else
          state_next = ADDR;
`endif
        end
      end
      ADDR:    state_next = CAPTURE;
      CAPTURE: state_next = SEND;
      HDR:     state_next = SEND;
      SEND: begin
        o_tx_start = 1'b1;
        state_next = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) begin
          if (byte_cnt != last_byte)     state_next = SEND;
          else if (hdr_phase)            state_next = ADDR;
          else if (word_cnt == LAST_WORD) state_next = DONE;
          else                           state_next = ADDR;
        end
      end
      DONE: begin
        o_done     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_tx_data = 8'h00;
    case (byte_cnt)
      2'd0: o_tx_data = word_reg[31:24];
      2'd1: o_tx_data = word_reg[23:16];
      2'd2: o_tx_data = word_reg[15:8];
      2'd3: o_tx_data = word_reg[7:0];
      default: o_tx_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_debug_mem_reader.sv
// tb/tb_debug_mem_reader.sv - randomized bench for debug_mem_reader with a byte-stream reference model.
// Honours DEBUG_MEM_HEADER_EN to expect the two header bytes.
module tb_debug_mem_reader;

`ifdef DEBUG_MEM_HEADER_EN
  localparam int HDRN = 2;
`else
  localparam int HDRN = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, tx_done, sel;
  logic [31:0] mem [0:15];
  logic [31:0] addr1, addr10, dato1, dato10;
  logic        ts1, ts10, bz1, bz10, dn1, dn10;
  logic [7:0]  td1, td10;
  logic        ts, bz, dn;
  logic [7:0]  td;
  logic [31:0] ad;
  int total = 0;
  int bad = 0;

  assign dato1  = mem[addr1[5:2]];
  assign dato10 = mem[addr10[5:2]];
  assign ts = sel ? ts10 : ts1;
  assign td = sel ? td10 : td1;
  assign bz = sel ? bz10 : bz1;
  assign dn = sel ? dn10 : dn1;
  assign ad = sel ? addr10 : addr1;

  debug_mem_reader #(.BITS_SIZE(32), .SIZE_MEM_DATA(1)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_start(start & ~sel),
    .o_addr_mem_debug(addr1), .i_mem_dato_debug(dato1),
    .o_tx_start(ts1), .o_tx_data(td1), .i_tx_done(tx_done & ~sel),
    .o_busy(bz1), .o_done(dn1)
  );

  debug_mem_reader #(.BITS_SIZE(32), .SIZE_MEM_DATA(10)) dut10 (
    .i_clk(clk), .i_reset(rst_n), .i_start(start & sel),
    .o_addr_mem_debug(addr10), .i_mem_dato_debug(dato10),
    .o_tx_start(ts10), .o_tx_data(td10), .i_tx_done(tx_done & sel),
    .o_busy(bz10), .o_done(dn10)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One dump: the model is simply the expected byte stream built from the memory array.
  task automatic dump(input bit s10, input int n, input bit noise, input int abort_at);
    logic [7:0]  exp[$];
    logic [7:0]  got[$];
    logic [31:0] wv;
    int cd, cyc, dones, j;
    bit fresh, first_seen;
    sel = s10;
    exp.delete();
    got.delete();
`ifdef DEBUG_MEM_HEADER_EN
    exp.push_back(8'hA5);
    exp.push_back(8'(n));
`endif
    for (int w = 0; w < n; w++) begin
      wv = mem[w];
      for (int b = 0; b < 4; b++) exp.push_back(wv[31-8*b -: 8]);
    end
    if (noise) begin
      @(negedge clk); tx_done = 1'b1;
      @(negedge clk); tx_done = 1'b0;
      chk("idle_after_spurious_done", {31'd0, bz}, 32'd0);
    end
    @(negedge clk); start = 1'b1;
    cd = 0; cyc = 0; dones = 0; first_seen = 1'b0;
    while (dones == 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      fresh = 1'b0;
      if (ts) begin
        if (!first_seen) begin
          chk("start_latency", cyc, (HDRN > 0) ? 2 : 3);
          first_seen = 1'b1;
        end
        chk("no_double_start", cd, 0);
        j = got.size() - HDRN;
        got.push_back(td);
        if (j >= 0 && j % 4 == 0) chk("addr", ad, j);
        cd = $urandom_range(1, 6);
        fresh = 1'b1;
      end else if (cd > 0) begin
        if (td !== got[got.size()-1]) chk("tx_hold", {24'd0, td}, {24'd0, got[got.size()-1]});
      end
      if (dn) begin
        dones++;
        chk("pulses_at_done", got.size(), exp.size());
      end
      if (abort_at > 0 && got.size() == abort_at && cd > 0 && !fresh) begin
        rst_n = 1'b0; start = 1'b0; tx_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", {31'd0, bz}, 32'd0);
        chk("abort_tx_start", {31'd0, ts}, 32'd0);
        chk("abort_addr", ad, 32'd0);
        chk("abort_tx_data", {24'd0, td}, 32'd0);
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          if (ts || bz) chk("abort_quiet", {30'd0, ts, bz}, 32'd0);
        end
        return;
      end
      start = noise && ($urandom_range(0, 9) == 0);
      tx_done = 1'b0;
      if (cd > 0 && !fresh) begin
        cd--;
        if (cd == 0) tx_done = 1'b1;
      end else if (fresh && noise && $urandom_range(0, 1) == 1) begin
        tx_done = 1'b1;
      end
    end
    start = 1'b0;
    tx_done = 1'b0;
    chk("done_count", dones, 1);
    chk("pulse_count", got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("byte%0d", i), {24'd0, got[i]}, {24'd0, exp[i]});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bz || ts || dn) chk("post_idle", {29'd0, bz, ts, dn}, 32'd0);
    end
    chk("busy_after", {31'd0, bz}, 32'd0);
    chk("addr_hold", ad, 32'((n - 1) * 4));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tx_done = 1'b0; sel = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", {30'd0, bz1, bz10}, 32'd0);
    chk("rst_done", {30'd0, dn1, dn10}, 32'd0);
    chk("rst_tx_start", {30'd0, ts1, ts10}, 32'd0);
    chk("rst_addr1", addr1, 32'd0);
    chk("rst_addr10", addr10, 32'd0);

    mem[0] = 32'h12345678;
    dump(1'b0, 1, 1'b0, -1);

    for (int i = 0; i < 10; i++) mem[i] = 32'hA0000000 + i;
    dump(1'b1, 10, 1'b0, -1);

    for (int i = 0; i < 10; i++) mem[i] = $urandom;
    dump(1'b1, 10, 1'b1, -1);

    dump(1'b1, 10, 1'b0, HDRN + 3 * 4 + 2);
    dump(1'b1, 10, 1'b0, -1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 10; i++) mem[i] = $urandom;
      if (r % 2 == 0) dump(1'b0, 1, 1'b1, -1);
      else            dump(1'b1, 10, 1'b1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
